slice_alu_sequencer: RTL and testbench
======================================

Name: slice_alu_sequencer

Overview:
- Multi-cycle controller for the bit-sliced ALU array and its slice interconnect.
- Accepts one ALU request at a time over a valid/ready handshake and loads operands into the slices.
- Issues the per-operation number of iteration steps: carry ripple for ADD, one bit per step for right shift, bit accumulation for POPCOUNT, single settle for COMPARE.
- Captures the interconnect's final result and compare code, then returns them over a valid/ready response channel.

Parameters:
- S, 4, slice width in bits.
- N_A, 2, number of slices; datapath width W = N_A*S.
- CW, $clog2(N_A*S+1), step-counter width (derived localparam, not overridable).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request.
- req_op  input  3  000 ADD, 001 SHR, 010 POPCOUNT, 011 CMP; others illegal.
- req_a  input  W  operand A.
- req_b  input  W  operand B.
- req_shamt  input  CW  right-shift amount, SHR only.
- dp_op  output  3  op driven to the slices and interconnect; held for the whole operation.
- dp_a  output  W  registered operand A to the slices.
- dp_b  output  W  registered operand B to the slices.
- dp_load  output  1  one-cycle pulse: slices load dp_a/dp_b.
- dp_step  output  1  slices advance one iteration.
- dp_result  input  W  final_out from the interconnect.
- dp_cmp  input  2  final_cmp from the interconnect (00 EQ).
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_result  output  W  captured result.
- rsp_cmp  output  2  captured compare code.
- rsp_err  output  1  illegal opcode flag.
- abort  input  1  synchronous flush.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (asynchronous, active-high) puts the FSM in IDLE.
  - Reset values: dp_op=000, dp_a=0, dp_b=0, rsp_result=0, rsp_cmp=00, counter=0.
  - Reset values: dp_load=0, dp_step=0, rsp_valid=0, rsp_err=0, busy=0, req_ready=1.
- FSM states: IDLE, LOAD, STEP, CAPTURE, DONE. All outputs are registered or decoded from state only; no combinational path from req_* to req_ready.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: latch op, a, b, shamt into dp_op/dp_a/dp_b, compute step count k, go to LOAD.
- Step count k:
  - ADD: k = N_A.
  - SHR: k = min(shamt, W).
  - POPCOUNT: k = W.
  - CMP: k = 1.
  - Illegal opcode: k = 0, err latched.
- LOAD: dp_load=1 for one cycle; counter <= k. If k==0, go to CAPTURE, else go to STEP.
- STEP: dp_step=1 every cycle; counter decrements; when counter==1, go to CAPTURE. Exactly k dp_step pulses per operation.
- CAPTURE:
  - rsp_result <= dp_result and rsp_cmp <= dp_cmp.
  - For an illegal opcode: rsp_result <= 0, rsp_cmp <= 00, rsp_err <= 1.
  - Then go to DONE.
- DONE:
  - rsp_valid=1; rsp_* held stable until rsp_valid&rsp_ready.
  - After the handshake: go to IDLE, rsp_valid drops and rsp_err clears next cycle.
- Latency: first rsp_valid cycle is k+3 cycles after the accept cycle.
  - ADD, N_A=2: 5.
  - CMP: 4.
  - SHR with shamt 0: 3.
  - POPCOUNT, W=8: 11.
- Minimum issue interval: k+4 cycles (one IDLE cycle between operations).
- dp_op, dp_a, dp_b are stable from LOAD through CAPTURE. They keep their last values in IDLE and DONE.
- Abort:
  - In any state other than IDLE: next state is IDLE, dp_load/dp_step drop, no response is produced, rsp_valid=0.
  - Abort in the same cycle as the rsp handshake: the response is counted as delivered, then IDLE.
  - Abort in IDLE: ignored; a request accepted in that cycle still proceeds.
- Reset mid-operation: immediately returns to IDLE with reset values; the in-flight op is lost.
- req_* are ignored in every state except IDLE.

Decomposition:
- Shared package slice_alu_pkg:
  - Opcode constants OP_ADD=000, OP_SHR=001, OP_POP=010, OP_CMP=011.
  - Compare code constants CMP_EQ=00 plus the non-EQ codes.
  - FSM state enumeration.
  - Step-count function step_count(op, shamt, N_A, S).
- One natural sub-module: slice_step_counter. Loadable down-counter, CW bits wide, with load, dec, and is_one/is_zero flags.

Test Plan:
- ADD, a=0x3A, b=0x47, dp_result model = a+b (0x81) -> dp_load pulse, 2 dp_step pulses, rsp_result=0x81, rsp_err=0, rsp_valid 5 cycles after accept.
- SHR, shamt=3, then shamt=0 -> 3 dp_step pulses, rsp_valid at +6; for shamt=0: zero dp_step pulses, rsp_valid at +3.
- POPCOUNT, a=0xFF -> 8 dp_step pulses, rsp_result=0x08, rsp_valid at +11; req_ready stays 0 throughout.
- CMP with dp_cmp model returning 10, rsp_ready held low 4 cycles -> rsp_cmp=10 held stable, rsp_valid stays high until handshake, req_ready=1 the cycle after.
- Illegal op 111 -> no dp_step, rsp_err=1, rsp_result=0, rsp_valid at +3; err clears after handshake.
- abort during 2nd POPCOUNT step -> dp_step low next cycle, no rsp_valid, IDLE and req_ready=1. Also: rst asserted mid-STEP -> all outputs at reset values immediately.

Source files
------------

// File: rtl/slice_alu_pkg.sv
// Shared definitions for the bit-sliced ALU sequencer: opcodes, compare codes,
// sequencer FSM states and the per-operation iteration-count function.
package slice_alu_pkg;

    // Opcodes driven to the slices and the interconnect
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SHR = 3'b001;
    localparam logic [2:0] OP_POP = 3'b010;
    localparam logic [2:0] OP_CMP = 3'b011;

    // Compare codes returned by the interconnect
    localparam logic [1:0] CMP_EQ = 2'b00;
    localparam logic [1:0] CMP_LT = 2'b01;
    localparam logic [1:0] CMP_GT = 2'b10;
    localparam logic [1:0] CMP_UN = 2'b11;

    // Sequencer FSM states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_STEP    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } seq_state_e;

    // True for the four opcodes the slice array understands
    function automatic logic is_legal_op(input logic [2:0] op);
        logic legal;
        case (op)
            OP_ADD, OP_SHR, OP_POP, OP_CMP: legal = 1'b1;
            default:                        legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Number of iteration steps the slices need for one operation:
    // carry ripples once per slice for ADD, SHR moves one bit per step
    // (never more than the datapath width), POPCOUNT accumulates every bit,
    // CMP needs a single settle step, illegal opcodes issue no steps.
    function automatic int unsigned step_count(input logic [2:0]  op,
                                               input int unsigned shamt,
                                               input int unsigned n_a,
                                               input int unsigned s);
        int unsigned w;
        int unsigned k;
        w = n_a * s;
        case (op)
            OP_ADD:  k = n_a;
            OP_SHR:  k = (shamt > w) ? w : shamt;
            OP_POP:  k = w;
            OP_CMP:  k = 32'd1;
            default: k = 32'd0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/slice_step_counter.sv
// Loadable down-counter that tracks the remaining iteration steps of the
// current operation. Decrementing saturates at zero so a stray dec can
// never wrap the counter around.
module slice_step_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          dec_i,
    output logic          is_one_o,
    output logic          is_zero_o
);

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: load wins over decrement, decrement stops at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != CNT_ZERO)) begin
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign is_one_o  = (cnt_q == CNT_ONE);
    assign is_zero_o = (cnt_q == CNT_ZERO);

endmodule

// File: rtl/slice_alu_sequencer.sv
// Multi-cycle controller for the bit-sliced ALU array. Accepts one request,
// loads the operands into the slices, issues the operation's iteration steps,
// captures the interconnect's final result and hands it back over a
// valid/ready response channel. Every output is a flop.
module slice_alu_sequencer
    import slice_alu_pkg::*;
#(
    parameter int S   = 4,
    parameter int N_A = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [2:0]                      req_op,
    input  logic [N_A*S-1:0]                req_a,
    input  logic [N_A*S-1:0]                req_b,
    input  logic [$clog2(N_A*S+1)-1:0]      req_shamt,
    output logic [2:0]                      dp_op,
    output logic [N_A*S-1:0]                dp_a,
    output logic [N_A*S-1:0]                dp_b,
    output logic                            dp_load,
    output logic                            dp_step,
    input  logic [N_A*S-1:0]                dp_result,
    input  logic [1:0]                      dp_cmp,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [N_A*S-1:0]                rsp_result,
    output logic [1:0]                      rsp_cmp,
    output logic                            rsp_err,
    input  logic                            abort,
    output logic                            busy
);

    localparam int W  = N_A * S;
    localparam int CW = $clog2(N_A * S + 1);

    seq_state_e     state_q;
    seq_state_e     state_d;

    logic           accept_s;
    logic [CW-1:0]  k_s;
    logic           cnt_is_one_s;
    logic           cnt_is_zero_s;
    logic           cnt_load_s;
    logic           cnt_dec_s;

    logic [2:0]     dp_op_q;
    logic [W-1:0]   dp_a_q;
    logic [W-1:0]   dp_b_q;
    logic [CW-1:0]  k_q;
    logic           illegal_q;

    logic           dp_load_q;
    logic           dp_step_q;
    logic           req_ready_q;
    logic           busy_q;
    logic           rsp_valid_q;

    logic [W-1:0]   rsp_result_q;
    logic [1:0]     rsp_cmp_q;
    logic           rsp_err_q;

    // Request acceptance and the step count of the incoming operation
    always_comb begin
        accept_s = (state_q == ST_IDLE) && req_valid;
        k_s      = CW'(step_count(req_op, 32'(req_shamt), N_A, S));
    end

    // Next-state logic; abort flushes every state except IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (k_q == {CW{1'b0}}) begin
                    state_d = ST_CAPTURE;
                end else begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                // is_zero only guards against a corrupted count
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (cnt_is_one_s || cnt_is_zero_s) begin
                    state_d = ST_CAPTURE;
                end else begin
                    state_d = ST_STEP;
                end
            end
            ST_CAPTURE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // A handshake coinciding with abort still counts as delivered
                if (abort || rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Control outputs registered from the next state so they line up with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_load_q   <= 1'b0;
            dp_step_q   <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            dp_load_q   <= (state_d == ST_LOAD);
            dp_step_q   <= (state_d == ST_STEP);
            req_ready_q <= (state_d == ST_IDLE);
            busy_q      <= (state_d != ST_IDLE);
            rsp_valid_q <= (state_d == ST_DONE);
        end
    end

    // Operand/opcode latch: updated only on accept, held otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_op_q   <= OP_ADD;
            dp_a_q    <= {W{1'b0}};
            dp_b_q    <= {W{1'b0}};
            k_q       <= {CW{1'b0}};
            illegal_q <= 1'b0;
        end else if (accept_s) begin
            dp_op_q   <= req_op;
            dp_a_q    <= req_a;
            dp_b_q    <= req_b;
            k_q       <= k_s;
            illegal_q <= ~is_legal_op(req_op);
        end else begin
            dp_op_q   <= dp_op_q;
            dp_a_q    <= dp_a_q;
            dp_b_q    <= dp_b_q;
            k_q       <= k_q;
            illegal_q <= illegal_q;
        end
    end

    // Response capture; illegal opcodes return a zeroed result with err set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_result_q <= {W{1'b0}};
            rsp_cmp_q    <= CMP_EQ;
            rsp_err_q    <= 1'b0;
        end else if ((state_q == ST_CAPTURE) && !abort) begin
            if (illegal_q) begin
                rsp_result_q <= {W{1'b0}};
                rsp_cmp_q    <= CMP_EQ;
                rsp_err_q    <= 1'b1;
            end else begin
                rsp_result_q <= dp_result;
                rsp_cmp_q    <= dp_cmp;
                rsp_err_q    <= 1'b0;
            end
        end else if ((state_q == ST_DONE) && (rsp_ready || abort)) begin
            rsp_result_q <= rsp_result_q;
            rsp_cmp_q    <= rsp_cmp_q;
            rsp_err_q    <= 1'b0;
        end else begin
            rsp_result_q <= rsp_result_q;
            rsp_cmp_q    <= rsp_cmp_q;
            rsp_err_q    <= rsp_err_q;
        end
    end

    // Step counter: loaded with k in LOAD, counts down once per step
    always_comb begin
        cnt_load_s = (state_q == ST_LOAD);
        cnt_dec_s  = (state_q == ST_STEP) && !abort;
    end

    slice_step_counter #(
        .CW (CW)
    ) u_step_counter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load_s),
        .load_val_i (k_q),
        .dec_i      (cnt_dec_s),
        .is_one_o   (cnt_is_one_s),
        .is_zero_o  (cnt_is_zero_s)
    );

    assign req_ready  = req_ready_q;
    assign busy       = busy_q;
    assign dp_op      = dp_op_q;
    assign dp_a       = dp_a_q;
    assign dp_b       = dp_b_q;
    assign dp_load    = dp_load_q;
    assign dp_step    = dp_step_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_cmp    = rsp_cmp_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_slice_alu_sequencer.sv
// Directed bench for slice_alu_sequencer with a small behavioural model of
// the slice array and interconnect driving dp_result/dp_cmp.
module tb_slice_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [2:0] req_op = 3'b000;
    logic [7:0] req_a = 8'h00;
    logic [7:0] req_b = 8'h00;
    logic [3:0] req_shamt = 4'd0;
    logic [2:0] dp_op;
    logic [7:0] dp_a;
    logic [7:0] dp_b;
    logic       dp_load;
    logic       dp_step;
    logic [7:0] dp_result;
    logic [1:0] dp_cmp;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_result;
    logic [1:0] rsp_cmp;
    logic       rsp_err;
    logic       abort = 1'b0;
    logic       busy;

    int err_cnt = 0;
    int chk_cnt = 0;
    int model_steps = 0;
    int load_total = 0;
    int step_total = 0;

    always #5 clk = ~clk;

    slice_alu_sequencer #(.S(4), .N_A(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_shamt  (req_shamt),
        .dp_op      (dp_op),
        .dp_a       (dp_a),
        .dp_b       (dp_b),
        .dp_load    (dp_load),
        .dp_step    (dp_step),
        .dp_result  (dp_result),
        .dp_cmp     (dp_cmp),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_cmp    (rsp_cmp),
        .rsp_err    (rsp_err),
        .abort      (abort),
        .busy       (busy)
    );

    // Slice array model: counts load/step pulses; SHR shifts once per step
    always @(posedge clk) begin
        if (dp_load) begin
            model_steps <= 0;
            load_total  <= load_total + 1;
        end else if (dp_step) begin
            model_steps <= model_steps + 1;
        end
        if (dp_step) step_total <= step_total + 1;
    end

    // Interconnect model; unknown opcodes produce a non-zero pattern
    always_comb begin
        dp_result = 8'hEE;
        dp_cmp    = 2'b11;
        case (dp_op)
            3'b000: begin dp_result = dp_a + dp_b;            dp_cmp = 2'b00; end
            3'b001: begin dp_result = dp_a >> model_steps;    dp_cmp = 2'b00; end
            3'b010: begin dp_result = 8'($countones(dp_a));   dp_cmp = 2'b00; end
            3'b011: begin
                dp_result = dp_a ^ dp_b;
                dp_cmp    = (dp_a > dp_b) ? 2'b10 : ((dp_a < dp_b) ? 2'b01 : 2'b00);
            end
            default: begin dp_result = 8'hEE; dp_cmp = 2'b11; end
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request, measure latency, check the response and handshake it
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [7:0] a, input logic [7:0] b, input logic [3:0] sh,
                          input int exp_k, input int exp_lat,
                          input logic [7:0] exp_res, input logic [1:0] exp_cmp,
                          input logic exp_err, input int hold, input logic abort_at_accept);
        int   lat;
        int   loads0;
        int   steps0;
        logic rr_bad;
        @(negedge clk);
        check_eq({tag, "_ready_idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_shamt = sh;
        abort = abort_at_accept;
        loads0 = load_total; steps0 = step_total;
        lat = 0; rr_bad = 1'b0;
        @(posedge clk);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) begin
                req_valid = 1'b0; abort = 1'b0; req_a = ~a; req_b = ~b; req_op = 3'b011;
            end
            if (rsp_valid) begin
                lat = i;
                break;
            end
            if (req_ready) rr_bad = 1'b1;
        end
        check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_ready_low"}, 32'(rr_bad), 32'd0);
        check_eq({tag, "_loads"}, 32'(load_total - loads0), 32'd1);
        check_eq({tag, "_steps"}, 32'(step_total - steps0), 32'(exp_k));
        check_eq({tag, "_result"}, 32'(rsp_result), 32'(exp_res));
        check_eq({tag, "_cmp"}, 32'(rsp_cmp), 32'(exp_cmp));
        check_eq({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        check_eq({tag, "_dp_a_held"}, 32'(dp_a), 32'(a));
        check_eq({tag, "_dp_op_held"}, 32'(dp_op), 32'(op));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            check_eq({tag, "_hold_result"}, 32'(rsp_result), 32'(exp_res));
            check_eq({tag, "_hold_cmp"}, 32'(rsp_cmp), 32'(exp_cmp));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
        check_eq({tag, "_err_clear"}, 32'(rsp_err), 32'd0);
        check_eq({tag, "_ready_after"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int   steps0;
        logic seen_valid;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready", 32'(req_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_load_step", 32'({dp_load, dp_step}), 32'd0);
        check_eq("rst_dp", 32'({dp_op, dp_a, dp_b}), 32'd0);
        rst = 1'b0;

        //        tag      op      a      b      sh     k  lat  res    cmp    err  hold abortIdle
        run_op("add",  3'b000, 8'h3A, 8'h47, 4'd0,  2, 5,  8'h81, 2'b00, 1'b0, 0, 1'b0);
        run_op("shr3", 3'b001, 8'hB4, 8'h00, 4'd3,  3, 6,  8'h16, 2'b00, 1'b0, 0, 1'b0);
        run_op("shr0", 3'b001, 8'h5C, 8'h00, 4'd0,  0, 3,  8'h5C, 2'b00, 1'b0, 0, 1'b0);
        run_op("shr12",3'b001, 8'hF0, 8'h00, 4'd12, 8, 11, 8'h00, 2'b00, 1'b0, 0, 1'b0);
        run_op("popff",3'b010, 8'hFF, 8'h00, 4'd0,  8, 11, 8'h08, 2'b00, 1'b0, 0, 1'b0);
        run_op("popa5",3'b010, 8'hA5, 8'h00, 4'd0,  8, 11, 8'h04, 2'b00, 1'b0, 0, 1'b0);
        run_op("cmp",  3'b011, 8'h90, 8'h21, 4'd0,  1, 4,  8'hB1, 2'b10, 1'b0, 4, 1'b0);
        run_op("ill",  3'b111, 8'h55, 8'h66, 4'd0,  0, 3,  8'h00, 2'b00, 1'b1, 0, 1'b1);

        // Abort during the second POPCOUNT step
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'b010; req_a = 8'h0F; req_b = 8'h00;
        steps0 = step_total;
        @(posedge clk);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("abort_step_low", 32'(dp_step), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_ready", 32'(req_ready), 32'd1);
        check_eq("abort_steps", 32'(step_total - steps0), 32'd2);
        seen_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (rsp_valid) seen_valid = 1'b1;
        end
        check_eq("abort_no_rsp", 32'(seen_valid), 32'd0);

        // Reset asserted mid-STEP
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'b010; req_a = 8'h3C; req_b = 8'h11;
        @(posedge clk);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        rst = 1'b1;
        #1;
        check_eq("rst_mid_step", 32'(dp_step), 32'd0);
        check_eq("rst_mid_ready", 32'(req_ready), 32'd1);
        check_eq("rst_mid_busy", 32'(busy), 32'd0);
        check_eq("rst_mid_dp", 32'({dp_op, dp_a, dp_b}), 32'd0);
        check_eq("rst_mid_rsp", 32'({rsp_result, rsp_cmp, rsp_err, rsp_valid, dp_load}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("add2", 3'b000, 8'hFF, 8'h02, 4'd0,  2, 5,  8'h01, 2'b00, 1'b0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
